// File: rtl/mem_stage.sv
// Memory stage of the five-stage MIPS pipeline plus the M/W pipeline register.
// Optional store trace: define DM_WRITE_LOG_EN to print every committed store.
module mem_stage #(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_Ins,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_ALU_Y,
  input  logic [31:0] M_RT_data,
  input  logic        M_branchTrue,
  output logic [31:0] W_Ins,
  output logic [31:0] W_PC,
  output logic [31:0] W_ALU_Y,
  output logic [31:0] W_DM_RD,
  output logic        W_branchTrue
);

  localparam int AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;

  logic [31:0]   mem_r [DM_WORDS];
  logic [5:0]    op_s;
  logic [1:0]    a_s;
  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic          store_en_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   merged_word_s;
  logic [31:0]   load_data_s;

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SW, OP_SH, OP_SB: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [5:0] op, input logic [31:0] old,
                                              input logic [31:0] data, input logic [1:0] a);
    store_merge = old;
    case (op)
      OP_SW: store_merge = data;
      OP_SH: begin
        if (a[1]) store_merge = {data[15:0], old[15:0]};
        else      store_merge = {old[31:16], data[15:0]};
      end
      OP_SB: begin
        case (a)
          2'd0:    store_merge = {old[31:8], data[7:0]};
          2'd1:    store_merge = {old[31:16], data[7:0], old[7:0]};
          2'd2:    store_merge = {old[31:24], data[7:0], old[15:0]};
          2'd3:    store_merge = {data[7:0], old[23:0]};
          default: store_merge = old;
        endcase
      end
      default: store_merge = old;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [31:0] word,
                                              input logic [1:0] a);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half = a[1] ? word[31:16] : word[15:0];
    case (a)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = 8'd0;
    endcase
    case (op)
      OP_LW:   load_extend = word;
      OP_LH:   load_extend = {{16{half[15]}}, half};
      OP_LHU:  load_extend = {16'd0, half};
      OP_LB:   load_extend = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_extend = {24'd0, byte_v};
      default: load_extend = 32'd0;
    endcase
  endfunction

  // Decode, address check, combinational word read, lane merge and load extension
  always_comb begin
    op_s       = M_Ins[31:26];
    a_s        = M_ALU_Y[1:0];
    idx_s      = M_ALU_Y[AW+1:2];
    in_range_s = ({2'b00, M_ALU_Y[31:2]} < 32'(DM_WORDS));
    if (in_range_s) begin
      rd_word_s = mem_r[idx_s];
    end else begin
      rd_word_s = 32'd0;
    end
    store_en_s    = is_store(op_s) && in_range_s;
    merged_word_s = store_merge(op_s, rd_word_s, M_RT_data, a_s);
    load_data_s   = load_extend(op_s, rd_word_s, a_s);
  end

  // Data memory: whole array cleared on reset, read-modify-write store otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem_r[AW'(i)] <= 32'd0;
      end
    end else if (store_en_s) begin
      mem_r[idx_s] <= merged_word_s;
`ifdef DM_WRITE_LOG_EN
      $display("%d@%h: *%h <= %h", $time, M_PC, {M_ALU_Y[31:2], 2'b00}, merged_word_s);
`endif
    end
  end

  // M/W pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      W_Ins        <= 32'd0;
      W_PC         <= 32'd0;
      W_ALU_Y      <= 32'd0;
      W_DM_RD      <= 32'd0;
      W_branchTrue <= 1'b0;
    end else begin
      W_Ins        <= M_Ins;
      W_PC         <= M_PC;
      W_ALU_Y      <= M_ALU_Y;
      W_DM_RD      <= load_data_s;
      W_branchTrue <= M_branchTrue;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions with hand-computed W-stage results.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_Ins, M_PC, M_ALU_Y, M_RT_data;
  logic        M_branchTrue;
  logic [31:0] W_Ins, W_PC, W_ALU_Y, W_DM_RD;
  logic        W_branchTrue;

  mem_stage #(.DM_WORDS(3072)) dut (
    .clk(clk), .reset(reset),
    .M_Ins(M_Ins), .M_PC(M_PC), .M_ALU_Y(M_ALU_Y), .M_RT_data(M_RT_data),
    .M_branchTrue(M_branchTrue),
    .W_Ins(W_Ins), .W_PC(W_PC), .W_ALU_Y(W_ALU_Y), .W_DM_RD(W_DM_RD),
    .W_branchTrue(W_branchTrue)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_SW   = 32'hAC0A0000;
  localparam logic [31:0] I_SH   = 32'hA40A0000;
  localparam logic [31:0] I_SB   = 32'hA00A0000;
  localparam logic [31:0] I_LW   = 32'h8C0B0000;
  localparam logic [31:0] I_LH   = 32'h840B0000;
  localparam logic [31:0] I_LHU  = 32'h940B0000;
  localparam logic [31:0] I_LB   = 32'h800B0000;
  localparam logic [31:0] I_LBU  = 32'h900B0000;
  localparam logic [31:0] I_ADDU = 32'h00851021;
  localparam logic [31:0] I_LUI  = 32'h3C0B0010;

  typedef struct {
    int          due;
    string       name;
    logic [31:0] ins, pc, alu, rd;
    logic        br;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] pc_r = 32'h00003000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: compare every entry whose capture edge has passed
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk({e.name, ".W_Ins"},        W_Ins,                 e.ins);
      chk({e.name, ".W_PC"},         W_PC,                  e.pc);
      chk({e.name, ".W_ALU_Y"},      W_ALU_Y,               e.alu);
      chk({e.name, ".W_DM_RD"},      W_DM_RD,               e.rd);
      chk({e.name, ".W_branchTrue"}, {31'd0, W_branchTrue}, {31'd0, e.br});
    end
  end

  task automatic issue(input string name, input logic rst, input logic [31:0] ins,
                       input logic [31:0] alu, input logic [31:0] rt, input logic br,
                       input logic [31:0] exp_rd);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    M_Ins        = ins;
    M_PC         = pc_r;
    M_ALU_Y      = alu;
    M_RT_data    = rt;
    M_branchTrue = br;
    e.due  = cyc + 1;
    e.name = name;
    if (rst) begin
      e.ins = 32'd0; e.pc = 32'd0; e.alu = 32'd0; e.rd = 32'd0; e.br = 1'b0;
    end else begin
      e.ins = ins; e.pc = pc_r; e.alu = alu; e.rd = exp_rd; e.br = br;
    end
    q.push_back(e);
    pc_r = pc_r + 32'd4;
  endtask

  initial begin
    int budget;
    reset = 1'b1; M_Ins = 32'd0; M_PC = 32'd0; M_ALU_Y = 32'd0;
    M_RT_data = 32'd0; M_branchTrue = 1'b0;

    issue("rst_idle",   1'b1, 32'd0, 32'd0,        32'd0,        1'b0, 32'd0);
    issue("rst_sw",     1'b1, I_SW,  32'h00000010, 32'hCAFEF00D, 1'b0, 32'd0);
    issue("lw_after_rst", 1'b0, I_LW, 32'h00000010, 32'd0,       1'b0, 32'd0);
    pc_r = 32'h00003004;
    issue("sw_10",      1'b0, I_SW,  32'h00000010, 32'hDEADBEEF, 1'b0, 32'd0);
    issue("lw_10",      1'b0, I_LW,  32'h00000010, 32'd0,        1'b0, 32'hDEADBEEF);
    issue("sb_11",      1'b0, I_SB,  32'h00000011, 32'h000000A5, 1'b0, 32'd0);
    issue("lw_10_b",    1'b0, I_LW,  32'h00000010, 32'd0,        1'b0, 32'hDEADA5EF);
    issue("lb_11",      1'b0, I_LB,  32'h00000011, 32'd0,        1'b0, 32'hFFFFFFA5);
    issue("lbu_11",     1'b0, I_LBU, 32'h00000011, 32'd0,        1'b0, 32'h000000A5);
    issue("lb_13",      1'b0, I_LB,  32'h00000013, 32'd0,        1'b0, 32'hFFFFFFDE);
    issue("lb_10",      1'b0, I_LB,  32'h00000010, 32'd0,        1'b0, 32'hFFFFFFEF);
    issue("lbu_12",     1'b0, I_LBU, 32'h00000012, 32'd0,        1'b0, 32'h000000AD);
    issue("lw_unalgn",  1'b0, I_LW,  32'h00000013, 32'd0,        1'b0, 32'hDEADA5EF);
    issue("sh_22",      1'b0, I_SH,  32'h00000022, 32'h12348001, 1'b0, 32'd0);
    issue("lh_22",      1'b0, I_LH,  32'h00000022, 32'd0,        1'b0, 32'hFFFF8001);
    issue("lhu_22",     1'b0, I_LHU, 32'h00000022, 32'd0,        1'b0, 32'h00008001);
    issue("lw_20",      1'b0, I_LW,  32'h00000020, 32'd0,        1'b0, 32'h80010000);
    issue("lh_20",      1'b0, I_LH,  32'h00000020, 32'd0,        1'b0, 32'h00000000);
    issue("sw_oor",     1'b0, I_SW,  32'h00003000, 32'h11111111, 1'b0, 32'd0);
    issue("lw_oor",     1'b0, I_LW,  32'h00003000, 32'd0,        1'b0, 32'd0);
    issue("sw_alias",   1'b0, I_SW,  32'h00004000, 32'h22222222, 1'b0, 32'd0);
    issue("lw_0",       1'b0, I_LW,  32'h00000000, 32'd0,        1'b0, 32'd0);
    issue("lw_last",    1'b0, I_LW,  32'h00002FFC, 32'd0,        1'b0, 32'd0);
    issue("addu",       1'b0, I_ADDU, 32'h00000007, 32'h5A5A5A5A, 1'b1, 32'd0);
    issue("lui_other",  1'b0, I_LUI, 32'h00000010, 32'd0,        1'b0, 32'd0);
    issue("lw_10_c",    1'b0, I_LW,  32'h00000010, 32'd0,        1'b1, 32'hDEADA5EF);
    issue("rst_lw",     1'b1, I_LW,  32'h00000010, 32'd0,        1'b0, 32'd0);
    issue("lw_10_clr",  1'b0, I_LW,  32'h00000010, 32'd0,        1'b0, 32'd0);
    issue("lw_20_clr",  1'b0, I_LW,  32'h00000020, 32'd0,        1'b0, 32'd0);
    issue("bubble",     1'b0, 32'd0, 32'd0,        32'd0,        1'b0, 32'd0);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
